// File: rtl/cog_pin_sync_if.sv
// Cog-side pin conditioner bundle: filter-length load, raw pads in, conditioned pins and edge strobes out.
// Latency: none (wiring only).  Backpressure: none; every signal is sampled or driven each cycle.
interface cog_pin_sync_if #(
    parameter int WIDTH = 32
);
    logic             ena;
    logic             setflt;
    logic [31:0]      data;
    logic [WIDTH-1:0] pin_raw;
    logic [WIDTH-1:0] pin_in;
    logic [WIDTH-1:0] pin_rise;
    logic [WIDTH-1:0] pin_fall;

    modport master (
        output ena, setflt, data, pin_raw,
        input  pin_in, pin_rise, pin_fall
    );

    modport slave (
        input  ena, setflt, data, pin_raw,
        output pin_in, pin_rise, pin_fall
    );
endinterface

// File: rtl/cog_pin_sync.sv
// Per-cog pin conditioner: 2-flop synchronizer, consecutive-sample glitch filter (PIN_SYNC_FILTER_EN), rise/fall strobes.
// Latency: 3+flt clk_cog edges from a stable pin_raw change to pin_in (fixed 3 when the filter is not built).
// Backpressure: none; every pin is conditioned every cycle and the strobes are single-cycle pulses.
module cog_pin_sync #(
    parameter int WIDTH     = 32,
    parameter int FILT_BITS = 4
) (
    input  logic           clk_cog,
    input  logic           res,
    cog_pin_sync_if.slave  bus
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] pin_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] pin_d;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;

    // Synchronizer runs regardless of ena so pin_in stays meaningful while the cog is idle.
    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.pin_raw;
            s2 <= s1;
        end
    end

`ifdef PIN_SYNC_FILTER_EN
    logic [FILT_BITS-1:0] flt;
    logic [FILT_BITS-1:0] cnt   [WIDTH];
    logic [FILT_BITS-1:0] cnt_d [WIDTH];
    logic                 unused_data_hi;

    assign unused_data_hi = ^bus.data[31:FILT_BITS];

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            flt <= '0;
        end else if (!bus.ena) begin
            flt <= '0;
        end else if (bus.setflt) begin
            flt <= bus.data[FILT_BITS-1:0];
        end
    end

    // >= rather than == so that lowering flt below a running count flips on the next mismatch.
    always_comb begin
        pin_d  = pin_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2[i] != pin_q[i]) begin
                if (cnt[i] >= flt) begin
                    pin_d[i]  = s2[i];
                    rise_d[i] = s2[i];
                    fall_d[i] = ~s2[i];
                end else begin
                    cnt_d[i] = cnt[i] + FILT_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_d[i];
            end
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{bus.ena, bus.setflt, bus.data};

    always_comb begin
        pin_d  = s2;
        rise_d = s2 & ~pin_q;
        fall_d = ~s2 & pin_q;
    end
`endif

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            pin_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            pin_q  <= pin_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign bus.pin_in   = pin_q;
    assign bus.pin_rise = rise_q;
    assign bus.pin_fall = fall_q;

endmodule

// File: doc/cog_pin_sync.md
Name: cog_pin_sync

Overview:
- Per-cog input-pin conditioner that sits directly upstream of the cog counters. It produces the `pin_in` vector those counters sample.
- Each raw pin goes through a two-flop synchronizer and then a programmable consecutive-sample glitch filter.
- It also emits one-cycle rise/fall strobes aligned to each accepted transition.
- Filter length is loaded by the cog with a write strobe, in the same style as the counter's `setctr`/`setfrq` loads.

Parameters:
- WIDTH, 32, number of pins conditioned.
- FILT_BITS, 4, width of the filter-length register and of each per-pin counter.

Ports:
- clk_cog  in   1  cog clock; all state updates on its rising edge.
- res  in  1  reset, asynchronous, active-high.
- ena  in  1  cog enable; low forces the filter length to 0 (synchronous).
- setflt  in  1  load filter length from data[FILT_BITS-1:0].
- data  in  32  cog write data.
- pin_raw  in  WIDTH  asynchronous pad inputs.
- pin_in  out  WIDTH  conditioned pin states (registered).
- pin_rise  out  WIDTH  one-cycle strobe: `pin_in` bit just went 0->1.
- pin_fall  out  WIDTH  one-cycle strobe: `pin_in` bit just went 1->0.

Behaviour:
- Reset (`res` high, asynchronous):
  - s1, s2, pin_in, all counters, flt, pin_rise and pin_fall are 0.
  - Reset takes effect immediately, including mid-count. There are no glitch strobes on entry.
- Filter-length register `flt`:
  - Priority: `ena` low -> 0; else `setflt` -> data[FILT_BITS-1:0]; else hold.
  - A new value is used from the next clock edge on.
- Synchronizer: s1 <= pin_raw, s2 <= s1, every edge, regardless of `ena`.
- Per pin i, every edge:
  - If s2[i] == pin_in[i]: cnt[i] <= 0; pin_rise[i] and pin_fall[i] <= 0.
  - If s2[i] != pin_in[i] and cnt[i] >= flt: pin_in[i] <= s2[i]; cnt[i] <= 0; pin_rise[i] <= s2[i]; pin_fall[i] <= ~s2[i].
  - If s2[i] != pin_in[i] and cnt[i] < flt: cnt[i] <= cnt[i]+1; strobes <= 0.
- Timing:
  - A transition is accepted after flt+1 consecutive mismatching s2 samples.
  - Latency from a stable `pin_raw` change to `pin_in` is 3+flt edges.
  - Strobes are asserted in exactly the cycle `pin_in` first shows the new value.
- Glitch rejection: a mismatch run shorter than flt+1 samples clears cnt when s2 returns to pin_in[i]. `pin_in` does not change and no strobe is generated.
- Width rule: cnt never exceeds flt, because it clears on flip and on match. With the >= compare, lowering flt mid-count below cnt flips on the next mismatching edge.
- flt = 0 is a pure synchronizer plus output register, with 3-edge latency.
- flt = 2^FILT_BITS-1 (15 by default) requires 16 consecutive samples.
- Pin i is independent of all other pins. Simultaneous transitions on many pins are handled in parallel.
- `setflt` and `ena` falling on the same edge: `ena` wins, so flt = 0.
- After reset release with pin_raw[i] = 1: pin_in[i] rises 3+flt edges later and pin_rise[i] pulses. Consumers must tolerate this.

Optional Feature:
- Macro: PIN_SYNC_FILTER_EN.
- Defined: the flt register and per-pin counters are built as described above.
- Undefined:
  - No flt register and no counters.
  - `setflt` and `data` are ignored.
  - pin_in <= s2 every edge, with a fixed 3-edge latency.
  - pin_rise = s2 & ~pin_in and pin_fall = ~s2 & pin_in, both registered alongside the `pin_in` update.
  - No glitch rejection; every 1-cycle s2 pulse propagates.

Test Plan:
- Reset, flt = 0; raise pin_raw[5] before edge 0 -> pin_in[5] = 1 after edge 2, pin_rise[5] = 1 for that single cycle only, pin_fall all 0.
- setflt with data = 3; 3-cycle-wide high pulse on pin_raw[0] -> pin_in[0] stays 0, no strobe. 4-cycle pulse -> pin_in[0] high after edge 6 from the pulse start, then falls 6 edges after the pulse ends, with one pin_fall[0] pulse.
- flt = 15; hold pin_raw[31] high -> pin_in[31] rises on edge 18 and not earlier; then setflt data = 0 mid-fall-count (cnt = 8) -> flip on the next edge.
- All 32 pins toggle simultaneously, flt = 2 -> pin_in == 32'hFFFFFFFF on the same edge and pin_rise == 32'hFFFFFFFF for one cycle.
- flt = 7, `ena` driven low together with `setflt` data = 5 -> flt reads as 0, with 3-edge latency on the next transition.
- Assert `res` asynchronously mid-count with pin_in = 32'hA5A5A5A5 -> all outputs 0 immediately without waiting for a clock edge. After release, pins that are still high re-rise 3+flt edges later (flt = 0 after reset).
